// File: rtl/jtag_vdr_bank.sv
// rtl/jtag_vdr_bank.sv - JTAG user-TAP tracker with VIR-selected bank of virtual data registers (option: JTAG_VDR_UPDATE_FLAG_EN)
module jtag_vdr_bank #(
  parameter int                NUM_CHANNELS = 4,
  parameter int                DR_WIDTH     = 8,
  parameter int                VIR_WIDTH    = 5,
  parameter int                IR_WIDTH     = 10,
  parameter logic [IR_WIDTH-1:0] IR_USER0   = 10'h00c,
  parameter logic [IR_WIDTH-1:0] IR_USER1   = 10'h00e
) (
  input  logic                             tckutap,
  input  logic                             reset,
  input  logic                             tmsutap,
  input  logic                             tdiutap,
  output logic                             tdouser,
  input  logic [NUM_CHANNELS*DR_WIDTH-1:0] cap_data,
  output logic [DR_WIDTH-1:0]              upd_data,
  output logic [NUM_CHANNELS-1:0]          upd_valid,
  output logic [VIR_WIDTH-1:0]             vir_sel
);

  // A single-channel bank still needs one select bit so that VIR=1 is rejected.
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  tap_state_t            state, next_state;
  logic [IR_WIDTH-1:0]   ir, ir_sr;
  logic [VIR_WIDTH-1:0]  vir_sr, vir_cap;
  logic [DR_WIDTH-1:0]   dr_sr, cap_sel;
  logic [CH_W-1:0]       ch;
  logic                  ch_valid;
  logic                  is_user0, is_user1;

  assign is_user0 = (ir == IR_USER0);
  assign is_user1 = (ir == IR_USER1);
  assign ch       = vir_sel[CH_W-1:0];
  assign ch_valid = (vir_sel[VIR_WIDTH-1:CH_W] == '0) && (32'(ch) < 32'(NUM_CHANNELS));

  // TAP state register
  always_ff @(posedge tckutap or posedge reset) begin
    if (reset) state <= TLR;
    else       state <= next_state;
  end

  // IEEE 1149.1 next-state decode
  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = tmsutap ? TLR      : RTI;
      RTI:      next_state = tmsutap ? SEL_DR   : RTI;
      SEL_DR:   next_state = tmsutap ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tmsutap ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = tmsutap ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = tmsutap ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tmsutap ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = tmsutap ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = tmsutap ? SEL_DR   : RTI;
      SEL_IR:   next_state = tmsutap ? TLR      : CAP_IR;
      CAP_IR:   next_state = tmsutap ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = tmsutap ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = tmsutap ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tmsutap ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = tmsutap ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = tmsutap ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // Instruction register: shift LSB-first, latch on Update-IR, clear on entering Test-Logic-Reset
  always_ff @(posedge tckutap or posedge reset) begin
    if (reset) begin
      ir    <= '0;
      ir_sr <= '0;
    end else begin
      case (state)
        CAP_IR:   ir_sr <= IR_WIDTH'(1);
        SHIFT_IR: ir_sr <= {tdiutap, ir_sr[IR_WIDTH-1:1]};
        UPD_IR:   ir    <= ir_sr;
        default:  ;
      endcase
      if (next_state == TLR) ir <= '0;
    end
  end

`ifdef JTAG_VDR_UPDATE_FLAG_EN
  logic upd_flag;

  // Sticky "something was updated" flag, reported in the VIR MSB and cleared by reading it
  always_ff @(posedge tckutap or posedge reset) begin
    if (reset) upd_flag <= 1'b0;
    else       upd_flag <= (((state == CAP_DR) && is_user1) ? 1'b0 : upd_flag) | (|upd_valid);
  end

  assign vir_cap = {upd_flag, vir_sel[VIR_WIDTH-2:0]};
`else
  assign vir_cap = vir_sel;
`endif

  // VIR chain, active while IR holds USER1
  always_ff @(posedge tckutap or posedge reset) begin
    if (reset) begin
      vir_sr  <= '0;
      vir_sel <= '0;
    end else if (is_user1) begin
      case (state)
        CAP_DR:   vir_sr  <= vir_cap;
        SHIFT_DR: vir_sr  <= {tdiutap, vir_sr[VIR_WIDTH-1:1]};
        UPD_DR:   vir_sel <= vir_sr;
        default:  ;
      endcase
    end
  end

  // Capture mux: selected channel's input, zero for an out-of-range select
  always_comb begin
    cap_sel = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (ch_valid && (ch == CH_W'(k))) cap_sel = cap_data[k*DR_WIDTH +: DR_WIDTH];
    end
  end

  // Data chain and registered update pulse, active while IR holds USER0
  always_ff @(posedge tckutap or posedge reset) begin
    if (reset) begin
      dr_sr     <= '0;
      upd_data  <= '0;
      upd_valid <= '0;
    end else begin
      upd_valid <= '0;
      if (is_user0) begin
        case (state)
          CAP_DR:   dr_sr <= cap_sel;
          SHIFT_DR: dr_sr <= {tdiutap, dr_sr[DR_WIDTH-1:1]};
          UPD_DR: begin
            if (ch_valid) begin
              upd_data <= dr_sr;
              for (int k = 0; k < NUM_CHANNELS; k++) upd_valid[k] <= (ch == CH_W'(k));
            end
          end
          default: ;
        endcase
      end
    end
  end

  // TDO launched on the falling edge from whichever chain the IR selects
  always_ff @(negedge tckutap or posedge reset) begin
    if (reset)         tdouser <= 1'b0;
    else if (is_user1) tdouser <= vir_sr[0];
    else if (is_user0) tdouser <= dr_sr[0];
    else               tdouser <= 1'b0;
  end

endmodule

// File: tb/tb_jtag_vdr_bank.sv
// tb/tb_jtag_vdr_bank.sv - randomized bench for jtag_vdr_bank against a scan-level reference model
module tb_jtag_vdr_bank;
  localparam logic [9:0] USER0 = 10'h00c;
  localparam logic [9:0] USER1 = 10'h00e;

  logic        tck = 1'b0;
  logic        rst, tms, tdi;
  logic        tdo;
  logic [31:0] cap_data;
  logic [7:0]  upd_data;
  logic [3:0]  upd_valid;
  logic [4:0]  vir_sel;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [9:0] m_ir;
  logic [4:0] m_vir;
  logic [7:0] m_upd;
  logic       m_flag;

  jtag_vdr_bank dut (
    .tckutap(tck), .reset(rst), .tmsutap(tms), .tdiutap(tdi), .tdouser(tdo),
    .cap_data(cap_data), .upd_data(upd_data), .upd_valid(upd_valid), .vir_sel(vir_sel)
  );

  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic tap_reset();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    m_ir = '0;
  endtask

  task automatic scan_ir(input logic [9:0] code);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(i == 9, code[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    m_ir = code;
  endtask

  // Idle -> DR scan of n bits (optional pause after pause_at bits) -> Update -> Idle
  task automatic scan_dr(input int n, input logic [31:0] din, input int pause_at, output logic [31:0] dout);
    logic brk;
    dout = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    if (n == 0) begin
      step(1'b1, 1'b0);
    end else begin
      step(1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
        dout[i] = tdo;
        brk = (pause_at > 0) && (i == pause_at - 1) && (i != n - 1);
        step((i == n - 1) || brk, din[i]);
        if (brk) begin
          repeat (4) step(1'b0, 1'b0);
          step(1'b1, 1'b0);
          step(1'b0, 1'b0);
        end
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic vir_scan(input logic [4:0] newv, input int pause_at);
    logic [31:0] dout;
    logic [4:0]  exp_out;
`ifdef JTAG_VDR_UPDATE_FLAG_EN
    exp_out = {m_flag, m_vir[3:0]};
    m_flag  = 1'b0;
`else
    exp_out = m_vir;
`endif
    scan_dr(5, {27'd0, newv}, pause_at, dout);
    check("vir_tdo", dout[4:0], exp_out);
    check("vir_no_pulse", upd_valid, 4'b0);
    m_vir = newv;
    check("vir_sel", vir_sel, m_vir);
    step(1'b0, 1'b0);
  endtask

  task automatic data_scan(input logic [7:0] din, input int n, input int pause_at);
    logic [31:0] dout, exp_tdo;
    logic [7:0]  cap, fin;
    logic [15:0] cat;
    logic [3:0]  exp_pulse;
    logic        sel_ok;
    sel_ok = (m_ir == USER0) && (int'(m_vir) < 4);
    cap = sel_ok ? cap_data[int'(m_vir)*8 +: 8] : 8'h00;
    cat = {din, cap} >> n;
    fin = cat[7:0];
    exp_tdo = (m_ir == USER0) ? ({24'd0, cap} & ((32'd1 << n) - 1)) : 32'd0;
    exp_pulse = 4'b0;
    if (sel_ok) begin
      exp_pulse = 4'b1 << m_vir;
      m_upd = fin;
      m_flag = 1'b1;
    end
    scan_dr(n, {24'd0, din}, pause_at, dout);
    check("dr_tdo", dout, exp_tdo);
    check("dr_pulse", upd_valid, exp_pulse);
    check("dr_upd_data", upd_data, m_upd);
    step(1'b0, 1'b0);
    check("dr_pulse_clear", upd_valid, 4'b0);
  endtask

  initial begin
    logic [4:0] v;
    rst = 1'b1; tms = 1'b1; tdi = 1'b0; cap_data = '0;
    m_ir = '0; m_vir = '0; m_upd = '0; m_flag = 1'b0;
    @(negedge tck); #1;
    check("rst_tdo", tdo, 1'b0);
    check("rst_vir", vir_sel, 5'd0);
    check("rst_upd_data", upd_data, 8'd0);
    check("rst_upd_valid", upd_valid, 4'd0);
    rst = 1'b0;

    // scenario 1: select channel 2 through the VIR
    tap_reset();
    scan_ir(USER1);
    vir_scan(5'h02, 0);

    // scenario 2: capture A5 from ch2, shift in 3C
    cap_data = {8'h11, 8'hA5, 8'h22, 8'h33};
    scan_ir(USER0);
    data_scan(8'h3C, 8, 0);

    // scenario 3: invalid select
    scan_ir(USER1);
    vir_scan(5'h04, 0);
    scan_ir(USER0);
    data_scan(8'h5A, 8, 0);

    // scenario 4: pause after 3 bits
    scan_ir(USER1);
    vir_scan(5'h02, 2);
    scan_ir(USER0);
    data_scan(8'h3C, 8, 3);

    // zero-shift scan updates with the captured value
    data_scan(8'h00, 0, 0);

    // unrelated IR value: no chain activity
    scan_ir(10'h3ff);
    data_scan(8'hFF, 8, 0);

    // randomized scans
    for (int it = 0; it < 16; it++) begin
      cap_data = $urandom;
      v = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      scan_ir(USER1);
      vir_scan(v, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0);
      scan_ir(USER0);
      data_scan(8'($urandom), int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
    end

`ifdef JTAG_VDR_UPDATE_FLAG_EN
    // scenario 6: flag read-and-clear through the VIR MSB
    scan_ir(USER1);
    vir_scan(5'h01, 0);
    scan_ir(USER0);
    data_scan(8'h81, 8, 0);
    scan_ir(USER1);
    vir_scan(5'h01, 0);
    vir_scan(5'h01, 0);
`endif

    // scenario 5: reset in the middle of a data scan
    scan_ir(USER1);
    vir_scan(5'h01, 0);
    scan_ir(USER0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    rst = 1'b1;
    #1;
    m_vir = '0; m_ir = '0; m_upd = '0; m_flag = 1'b0;
    check("midrst_vir", vir_sel, 5'd0);
    check("midrst_tdo", tdo, 1'b0);
    check("midrst_pulse", upd_valid, 4'd0);
    check("midrst_upd_data", upd_data, 8'd0);
    step(1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(i < 2, 1'b0);
      check("post_rst_pulse", upd_valid, 4'd0);
    end
    check("post_rst_vir", vir_sel, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
